mips_multi_ctrl: RTL
====================

MIPS_MULTI_CTRL -- requirements
Module: mips_multi_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0, extra wait cycles per memory access (0..15).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports opcode  input  6 and funct  input  6, taken from the instruction register.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have outputs pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, each 1 bit.
REQ-007 SHALL have outputs alu_src_b  2, alu_op  2 (00 add, 01 sub, 10 funct), pc_source  2 (00 ALU, 01 ALUOut, 10 jump).
REQ-008 SHALL have outputs state  4 (current state code) and illegal  1 (one-cycle pulse).

Function
REQ-009 SHALL implement Moore FSM states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, HALT=10.
REQ-010 SHALL go FETCH->DECODE, then by opcode: 35/43->MEM_ADDR, 0->EXECUTE, 4->BRANCH, 2->JUMP.
REQ-011 SHALL go MEM_ADDR->MEM_READ (op 35) or MEM_WRITE (op 43); MEM_READ->MEM_WB; MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP->FETCH; EXECUTE->R_WB.
REQ-012 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write=1 only on the final FETCH cycle.
REQ-013 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
REQ-014 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; MEM_READ: mem_read=1, i_or_d=1; MEM_WRITE: mem_write=1, i_or_d=1; MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
REQ-015 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; R_WB: reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-016 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; JUMP: pc_write=1, pc_source=10.
REQ-017 All outputs not listed for a state SHALL be 0; reg_write, mem_write, pc_write, ir_write SHALL never be asserted in the same cycle as each other except pc_write with ir_write in FETCH.
REQ-018 FETCH, MEM_READ, MEM_WRITE SHALL each last exactly MEM_WAIT+1 cycles, holding their outputs; wait counter SHALL clear on every state entry.
REQ-019 Cycles per instruction with MEM_WAIT=W: R-type 4+W, LW 5+2W, SW 4+2W, BEQ 3+W, J 3+W.
REQ-020 Opcode outside {0,2,4,35,43}, or opcode 0 with funct outside {32,34,36,37}, SHALL be illegal: illegal pulses 1 cycle in DECODE.
REQ-021 opcode/funct SHALL be sampled only in DECODE and MEM_ADDR; changes in other states SHALL have no effect.

Reset
REQ-022 rst low SHALL immediately force state=FETCH, wait counter=0, illegal=0, regardless of clock or state mid-instruction.
REQ-023 While rst low, all write enables (pc_write, pc_write_cond, ir_write, reg_write, mem_write) SHALL be 0; first FETCH cycle begins on the first rising clk edge after rst high.

Configuration
REQ-024 With MIPS_CTRL_ILLEGAL_TRAP_EN defined, an illegal instruction SHALL go DECODE->HALT; HALT outputs all 0 and is left only by reset.
REQ-025 Without MIPS_CTRL_ILLEGAL_TRAP_EN, an illegal instruction SHALL go DECODE->FETCH (executed as NOP, 2+W cycles); HALT SHALL be unreachable.

Structure
REQ-026 Package mips_ctrl_pkg SHALL hold state encodings, opcode constants (R=0, J=2, BEQ=4, LW=35, SW=43), funct constants (32,34,36,37), alu_op and pc_source codes.
REQ-027 Wait counter SHALL be a sub-module mips_mem_wait_cnt (load on state entry, done flag at MEM_WAIT).

Verification
REQ-028 MEM_WAIT=0, ADD (op 0, funct 32) -> states 0,1,6,7,0; reg_write=1 only in cycle 4, reg_dst=1.
REQ-029 MEM_WAIT=2, LW (op 35) -> 3 FETCH, 1 DECODE, 1 MEM_ADDR, 3 MEM_READ, 1 MEM_WB cycles = 9; ir_write once, on cycle 3.
REQ-030 BEQ with zero=1 -> pc_write_cond=1, pc_source=01 in state 8; zero=0 -> same outputs, next state FETCH, 3 cycles total.
REQ-031 Opcode 63 -> illegal=1 one cycle in DECODE; with MIPS_CTRL_ILLEGAL_TRAP_EN state stays 10 for 20 cycles; without, state returns to 0.
REQ-032 rst driven low mid-MEM_WRITE (SW, MEM_WAIT=3, 2nd wait cycle) -> mem_write=0 and state=0 before next clk edge; clean FETCH after release.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM state codes,
// opcode/funct values, ALU operation and PC source selects, legality check.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_HALT      = 4'd10
    } state_t;

    localparam logic [5:0] OP_R   = 6'd0;
    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_SW  = 6'd43;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // ALU B operand selects: register, constant 4, sign-ext imm, shifted imm
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    function automatic logic is_legal(input logic [5:0] op,
                                      input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_R: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_mem_wait_cnt.sv
// Memory wait counter: cleared on every state entry, counts up to MEM_WAIT.
// Ports: clk, rst (async active-low), load (state entry), done (count reached).
module mips_mem_wait_cnt #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam logic [3:0] LIMIT = 4'(MEM_WAIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign done = (cnt_q == LIMIT);

    // Saturates at LIMIT so a long-lived state keeps done asserted.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (!done) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_multi_ctrl.sv
// Multi-cycle MIPS control unit (Moore FSM) with per-access memory wait.
// Inputs: clk, rst (async active-low), opcode, funct, zero. Outputs: datapath
// enables/selects, state code, illegal pulse. Option: MIPS_CTRL_ILLEGAL_TRAP_EN.
module mips_multi_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal
);

    state_t state_q;
    state_t state_d;
    logic   run_q;
    logic   run_d;
    logic   wait_done;
    logic   wait_load;
    logic   dec_illegal;
    logic   zero_unused;

    // Branch resolution happens in the datapath; the FSM itself ignores it.
    assign zero_unused = zero;
    assign dec_illegal = !is_legal(opcode, funct);
    assign state       = state_q;

    // run_q holds off the first FETCH until the first edge after release,
    // so a partial cycle between release and the edge never counts.
    assign wait_load = !run_q || (state_d != state_q);

    mips_mem_wait_cnt #(
        .MEM_WAIT (MEM_WAIT)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (wait_load),
        .done (wait_done)
    );

    always_comb begin
        state_d = state_q;
        run_d   = 1'b1;
        if (!run_q) begin
            state_d = S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (wait_done) state_d = S_DECODE;
                end
                S_DECODE: begin
                    if (dec_illegal) begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                        state_d = S_HALT;
`else
                        state_d = S_FETCH;
`endif
                    end else begin
                        case (opcode)
                            OP_LW, OP_SW: state_d = S_MEM_ADDR;
                            OP_R:         state_d = S_EXECUTE;
                            OP_BEQ:       state_d = S_BRANCH;
                            OP_J:         state_d = S_JUMP;
                            default:      state_d = S_FETCH;
                        endcase
                    end
                end
                S_MEM_ADDR: begin
                    state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    if (wait_done) state_d = S_MEM_WB;
                end
                S_MEM_WRITE: begin
                    if (wait_done) state_d = S_FETCH;
                end
                S_EXECUTE: state_d = S_R_WB;
                S_MEM_WB, S_R_WB,
                S_BRANCH, S_JUMP: state_d = S_FETCH;
                S_HALT: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_FETCH;
`endif
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PC_ALU;
        illegal       = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = wait_done;
                pc_write  = wait_done;
            end
            S_DECODE: begin
                alu_src_b = SRCB_BR;
                illegal   = dec_illegal;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_JUMP;
            end
            default: begin
            end
        endcase
        // run_q drops asynchronously with rst, so this also covers reset.
        if (!run_q) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_write     = 1'b0;
            illegal       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

endmodule
